// File: rtl/key_debounce_scan_if.sv
// Signal bundle between the raw note switches, the debouncer and its consumers.
// The master side is the debouncer; the slave side drives the switches and reads the results.
interface key_debounce_scan_if;
  logic [7:0] SW_RAW;
  logic [7:0] KEY_N;
  logic [7:0] PRESS;
  logic [7:0] RELEASE;
  logic       NOTE_VALID;
  logic [2:0] NOTE_IDX;
  logic       TICK_1MS;

  modport master (
    input  SW_RAW,
    output KEY_N, PRESS, RELEASE, NOTE_VALID, NOTE_IDX, TICK_1MS
  );

  modport slave (
    output SW_RAW,
    input  KEY_N, PRESS, RELEASE, NOTE_VALID, NOTE_IDX, TICK_1MS
  );
endinterface

// File: rtl/key_debounce_scan.sv
// Eight-key synchroniser and tick-based debouncer with press/release pulses
// and a lowest-index priority encoder for the note display.
module key_debounce_scan #(
  parameter int CLK_HZ      = 12000000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic                CLK_IN,
  input  logic                RST_N,
  key_debounce_scan_if.master bus
);

  localparam int PRESC_N = CLK_HZ / 1000;
  localparam int PW      = (PRESC_N > 1) ? $clog2(PRESC_N) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_N - 1);
  localparam logic [7:0]    CNT_LAST   = 8'(DEBOUNCE_MS - 1);

  logic [7:0]    sync1_q, sync1_d;
  logic [7:0]    sync2_q, sync2_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic [7:0]    key_q, key_d;
  logic [7:0]    press_q, press_d;
  logic [7:0]    rel_q, rel_d;
  logic [7:0]    cnt_q [8];
  logic [7:0]    cnt_d [8];
  logic          valid_q, valid_d;
  logic [2:0]    idx_q, idx_d;

  // Lowest-numbered pressed (zero) key; 0 when nothing is pressed.
  function automatic logic [2:0] lowest_zero(input logic [7:0] v);
    logic [2:0] r;
    casez (v)
      8'b???????0: r = 3'd0;
      8'b??????01: r = 3'd1;
      8'b?????011: r = 3'd2;
      8'b????0111: r = 3'd3;
      8'b???01111: r = 3'd4;
      8'b??011111: r = 3'd5;
      8'b?0111111: r = 3'd6;
      8'b01111111: r = 3'd7;
      default:     r = 3'd0;
    endcase
    return r;
  endfunction

  // Two-stage synchroniser on the raw switches.
  always_comb begin
    sync1_d = bus.SW_RAW;
    sync2_d = sync1_q;
  end

  // 1 ms prescaler; the strobe lands in the cycle after the terminal count.
  always_comb begin
    if (presc_q == PRESC_LAST) begin
      presc_d = {PW{1'b0}};
      tick_d  = 1'b1;
    end else begin
      presc_d = presc_q + PW'(1);
      tick_d  = 1'b0;
    end
  end

  // Per-key debounce: any agreement with the current state restarts the interval.
  always_comb begin
    key_d   = key_q;
    press_d = 8'h00;
    rel_d   = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == key_q[i]) begin
        cnt_d[i] = 8'd0;
      end else if (tick_q && (cnt_q[i] == CNT_LAST)) begin
        key_d[i]   = sync2_q[i];
        cnt_d[i]   = 8'd0;
        press_d[i] = ~sync2_q[i];
        rel_d[i]   = sync2_q[i];
      end else if (tick_q) begin
        cnt_d[i] = cnt_q[i] + 8'd1;
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // Priority encoder works from the registered key state, one cycle behind it.
  always_comb begin
    valid_d = ~&key_q;
    idx_d   = lowest_zero(key_q);
  end

  // State registers.
  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= 8'hFF;
      sync2_q <= 8'hFF;
      presc_q <= {PW{1'b0}};
      tick_q  <= 1'b0;
      key_q   <= 8'hFF;
      press_q <= 8'h00;
      rel_q   <= 8'h00;
      valid_q <= 1'b0;
      idx_q   <= 3'd0;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= 8'd0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      key_q   <= key_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign bus.KEY_N      = key_q;
  assign bus.PRESS      = press_q;
  assign bus.RELEASE    = rel_q;
  assign bus.NOTE_VALID = valid_q;
  assign bus.NOTE_IDX   = idx_q;
  assign bus.TICK_1MS   = tick_q;

endmodule
